// File: rtl/seg7_load_if.sv
// Load port carrying a 16-bit value into the 7-segment scan driver.
// Plain valid/ready handshake: a transfer happens on a clock edge with both high.
interface seg7_load_if;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit hex scan driver for a common-segment 7-segment display.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
   parameter int REFRESH_DIV = 50000,
   parameter int DIV_W       = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   seg7_load_if.slave  load,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_start
);

   logic [DIV_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      shown;
   logic [15:0]      pending;
   logic             full;
   logic             tick;
   logic             boundary;
   logic [3:0]       nib;
   logic [6:0]       enc;
   logic             blank;

   assign tick     = (cnt == DIV_W'(REFRESH_DIV - 1));
   assign boundary = tick && (idx == 2'd3);
   assign load.load_ready = ~full;

   always_comb begin
      nib = 4'h0;
      case (idx)
         2'd0: nib = shown[3:0];
         2'd1: nib = shown[7:4];
         2'd2: nib = shown[11:8];
         2'd3: nib = shown[15:12];
         default: nib = 4'h0;
      endcase
   end

   always_comb begin
      enc = 7'b0000000;
      case (nib)
         4'h0: enc = 7'b1111110;
         4'h1: enc = 7'b0110000;
         4'h2: enc = 7'b1101101;
         4'h3: enc = 7'b1111001;
         4'h4: enc = 7'b0110011;
         4'h5: enc = 7'b1011011;
         4'h6: enc = 7'b1011111;
         4'h7: enc = 7'b1110000;
         4'h8: enc = 7'b1111111;
         4'h9: enc = 7'b1111011;
         4'hA: enc = 7'b1110111;
         4'hB: enc = 7'b0011111;
         4'hC: enc = 7'b1001110;
         4'hD: enc = 7'b0111101;
         4'hE: enc = 7'b1001111;
         4'hF: enc = 7'b1000111;
         default: enc = 7'b0000000;
      endcase
   end

`ifdef SEG7_LZ_BLANK_EN
   logic [1:0] msd;

   // Most significant nonzero digit; an all-zero value still lights digit 0.
   always_comb begin
      msd = 2'd0;
      if (shown[7:4]   != 4'h0) msd = 2'd1;
      if (shown[11:8]  != 4'h0) msd = 2'd2;
      if (shown[15:12] != 4'h0) msd = 2'd3;
   end

   assign blank = (idx > msd);
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (tick) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   // Apply only on the frame wrap so a new value never tears mid-frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shown   <= 16'h0000;
         pending <= 16'h0000;
         full    <= 1'b0;
      end else if (boundary && full) begin
         shown <= pending;
         full  <= 1'b0;
      end else if (load.load_valid && !full) begin
         pending <= load.load_data;
         full    <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg         <= 7'b0000000;
         an          <= 4'b0000;
         frame_start <= 1'b0;
      end else begin
         seg         <= blank ? 7'b0000000 : enc;
         an          <= 4'b0001 << idx;
         frame_start <= boundary;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4 (16-cycle frames).
// Cycle k counts rising edges since reset release; frames start at k=16n+1.
module tb_seg7_scan_driver;

   localparam logic [6:0] H0 = 7'b1111110;
   localparam logic [6:0] H1 = 7'b0110000;
   localparam logic [6:0] H2 = 7'b1101101;
   localparam logic [6:0] H3 = 7'b1111001;
   localparam logic [6:0] H4 = 7'b0110011;
   localparam logic [6:0] H5 = 7'b1011011;
   localparam logic [6:0] H6 = 7'b1011111;
   localparam logic [6:0] H7 = 7'b1110000;
   localparam logic [6:0] H8 = 7'b1111111;
   localparam logic [6:0] H9 = 7'b1111011;
   localparam logic [6:0] HA = 7'b1110111;
   localparam logic [6:0] HC = 7'b1001110;
   localparam logic [6:0] HE = 7'b1001111;
   localparam logic [6:0] HF = 7'b1000111;
   localparam logic [6:0] OFF = 7'b0000000;

   logic       clk;
   logic       rst_n;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_start;
   int         kc;
   int         errs;
   int         checks;

   seg7_load_if lif ();

   seg7_scan_driver #(
      .REFRESH_DIV (4),
      .DIV_W       (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (lif),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s k=%0d got=%h exp=%h", tag, kc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      kc++;
   endtask

   task automatic go(input int n);
      while (kc < n) step();
   endtask

   // s[d] is the expected segment pattern of digit d in the frame at k0.
   task automatic frame(input string tag, input int k0,
                        input logic [3:0][6:0] s);
      for (int d = 0; d < 4; d++) begin
         go(k0 + 4 * d);
         chk({tag, "_an"}, 16'(an), 16'(4'b0001 << d));
         chk({tag, "_seg"}, 16'(seg), 16'(s[d]));
      end
      go(k0 + 14);
      chk({tag, "_fs0"}, 16'(frame_start), 16'd0);
      go(k0 + 15);
      chk({tag, "_fs1"}, 16'(frame_start), 16'd1);
   endtask

   task automatic send(input logic [15:0] v);
      lif.load_valid = 1'b1;
      lif.load_data  = v;
      step();
      lif.load_valid = 1'b0;
   endtask

   initial begin
      errs = 0;
      checks = 0;
      kc = 0;
      rst_n = 1'b0;
      lif.load_valid = 1'b0;
      lif.load_data = 16'h0000;
      repeat (3) step();
      chk("rst_seg", 16'(seg), 16'd0);
      chk("rst_an", 16'(an), 16'd0);
      chk("rst_fs", 16'(frame_start), 16'd0);
      chk("rst_rdy", 16'(lif.load_ready), 16'd1);
      rst_n = 1'b1;
      kc = 0;
      #2;
      chk("rel_an", 16'(an), 16'd0);

      // 1: first frame shows 0000
      frame("f1", 1, {H0, H0, H0, H0});

      // 2: mid-frame load waits for the boundary
      go(18);
      send(16'hA5C3);
      chk("t2_rdy0", 16'(lif.load_ready), 16'd0);
      go(29);
      chk("t2_old", 16'(seg), 16'(H0));
      go(31);
      chk("t2_rdy31", 16'(lif.load_ready), 16'd0);
      go(32);
      chk("t2_rdy32", 16'(lif.load_ready), 16'd1);
      frame("f3", 33, {HA, H5, HC, H3});

      // 3: second load held off while pending full
      go(50);
      lif.load_valid = 1'b1;
      lif.load_data = 16'h1234;
      step();
      lif.load_data = 16'h5678;
      chk("t3_rdy0", 16'(lif.load_ready), 16'd0);
      go(64);
      chk("t3_rdy64", 16'(lif.load_ready), 16'd1);
      step();
      lif.load_valid = 1'b0;
      chk("t3_rdy65", 16'(lif.load_ready), 16'd0);
      frame("f5", 65, {H1, H2, H3, H4});
      chk("t3_rdy80", 16'(lif.load_ready), 16'd1);
      frame("f6", 81, {H5, H6, H7, H8});

      // 4: load on the boundary cycle lands one frame later
      go(111);
      send(16'h9E0F);
      chk("t4_rdy", 16'(lif.load_ready), 16'd0);
      frame("f8", 113, {H5, H6, H7, H8});
      frame("f9", 129, {H9, HE, H0, HF});

      // 5: reset mid-digit drops the pending value
      go(146);
      send(16'hBEEF);
      chk("t5_rdy", 16'(lif.load_ready), 16'd0);
      go(150);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_seg", 16'(seg), 16'd0);
      chk("t5_an", 16'(an), 16'd0);
      chk("t5_rdy_rst", 16'(lif.load_ready), 16'd1);
      repeat (2) step();
      rst_n = 1'b1;
      kc = 0;
      frame("r1", 1, {H0, H0, H0, H0});
      chk("t5_rdy16", 16'(lif.load_ready), 16'd1);
      frame("r2", 17, {H0, H0, H0, H0});

      // 6: leading zeros, blanked only when the option is built in
      go(34);
      send(16'h0042);
`ifdef SEG7_LZ_BLANK_EN
      frame("lz1", 49, {OFF, OFF, H4, H2});
`else
      frame("lz1", 49, {H0, H0, H4, H2});
`endif
      go(66);
      send(16'h0000);
`ifdef SEG7_LZ_BLANK_EN
      frame("lz2", 81, {OFF, OFF, OFF, H0});
`else
      frame("lz2", 81, {H0, H0, H0, H0});
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
